// File: rtl/aritmetica_mac_pkg.sv
// Shared types and constants for the aritmetica_mac multiply-accumulate block.
package aritmetica_mac_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACUM     = 2'd1,
        REDONDEO = 2'd2,
        SALIDA   = 2'd3
    } estado_t;

    function automatic longint sat_max(input int n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int n);
        return -(64'sd1 <<< (n - 1));
    endfunction

    // Half an LSB of the output word, added before the truncating shift.
    function automatic longint round_const(input int frac);
        return (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
    endfunction

endpackage

// File: rtl/aritmetica_mac_redondeo_sat.sv
// Round-half-up and saturate a wide accumulator down to an N-bit word.
module redondeo_sat
    import aritmetica_mac_pkg::*;
#(
    parameter int N     = 24,
    parameter int FRAC  = 8,
    parameter int GUARD = 4
) (
    input  logic signed [2*N+GUARD-1:0] acc,
    output logic signed [N-1:0]         dato,
    output logic                        sat
);

    localparam int W = 2 * N + GUARD;
    localparam logic signed [W:0] RND  = (W + 1)'(round_const(FRAC));
    localparam logic signed [W:0] MAXV = (W + 1)'(sat_max(N));
    localparam logic signed [W:0] MINV = (W + 1)'(sat_min(N));

    // One extra bit so adding the rounding constant can never wrap.
    logic signed [W:0] suma;
    logic signed [W:0] desplazado;

    always_comb begin
        suma       = $signed({acc[W-1], acc}) + RND;
        desplazado = suma >>> FRAC;
        dato       = desplazado[N-1:0];
        sat        = 1'b0;
        if (desplazado > MAXV) begin
            dato = MAXV[N-1:0];
            sat  = 1'b1;
        end else if (desplazado < MINV) begin
            dato = MINV[N-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/aritmetica_mac.sv
// Frame-based signed MAC: TAPS coef*sample products plus an offset, rounded and saturated.
module aritmetica_mac
    import aritmetica_mac_pkg::*;
#(
    parameter int N     = 24,
    parameter int FRAC  = 8,
    parameter int TAPS  = 3,
    parameter int GUARD = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] in_coef,
    input  logic signed [N-1:0] in_dato,
    input  logic signed [N-1:0] in_ofs,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] out_dato,
    output logic                out_sat
);

    localparam int W  = 2 * N + GUARD;
    localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(TAPS - 1);

    estado_t                estado;
    logic [CW-1:0]          cnt;
    logic signed [W-1:0]    acc;
    logic signed [2*N-1:0]  prod;
    logic signed [W-1:0]    prod_ext;
    logic signed [W-1:0]    ofs_ext;
    logic signed [N-1:0]    red_dato;
    logic                   red_sat;
    logic                   acepta;

    assign in_ready  = (estado == IDLE) || (estado == ACUM);
    assign out_valid = (estado == SALIDA);
    assign acepta    = in_valid && in_ready;

    assign prod     = in_coef * in_dato;
    assign prod_ext = {{GUARD{prod[2*N-1]}}, prod};
    assign ofs_ext  = {{(W-N){in_ofs[N-1]}}, in_ofs} <<< FRAC;

    redondeo_sat #(
        .N     (N),
        .FRAC  (FRAC),
        .GUARD (GUARD)
    ) u_redondeo_sat (
        .acc  (acc),
        .dato (red_dato),
        .sat  (red_sat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            out_dato <= '0;
            out_sat  <= 1'b0;
        end else begin
            case (estado)
                IDLE, ACUM: begin
                    if (acepta) begin
                        // Beat 0 restarts the frame: the offset replaces the old sum.
                        if (cnt == '0)
                            acc <= ofs_ext + prod_ext;
                        else
                            acc <= acc + prod_ext;
                        if (cnt == ULTIMO) begin
                            cnt    <= '0;
                            estado <= REDONDEO;
                        end else begin
                            cnt    <= cnt + 1'b1;
                            estado <= ACUM;
                        end
                    end
                end
                REDONDEO: begin
                    out_dato <= red_dato;
                    out_sat  <= red_sat;
                    estado   <= SALIDA;
                end
                SALIDA: begin
                    if (out_ready)
                        estado <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule
